// File: rtl/register_bank_pkg.sv
// register_bank_pkg
//   Shared definitions for the register bank: function-select codes and
//   sizing helpers for the lane and register index widths.
package register_bank_pkg;

    // Function-select codes; 3'b101..3'b111 hold.
    localparam logic [2:0] FS_CLR  = 3'b000;
    localparam logic [2:0] FS_LOAD = 3'b001;
    localparam logic [2:0] FS_DEC  = 3'b010;
    localparam logic [2:0] FS_INC  = 3'b011;
    localparam logic [2:0] FS_LANE = 3'b100;

    // Number of LANE-wide lanes in a WIDTH-bit register.
    function automatic int nlane(input int width, input int lane);
        return width / lane;
    endfunction

    // Width of an index selecting one of n items; never below 1 bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/register_bank_cell.sv
// reg_cell
//   One register of the bank. It applies the shared function select when
//   its write enable is high, and flags when the current operation is an
//   inc/dec that starts at the boundary value.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   we         write enable for this register (global enable & mask bit)
//   funsel     operation code
//   lanesel    lane index for lane loads
//   load       full-width load data
//   lane_data  lane load data
//   q          register contents
//   bnd        inc of all-ones or dec of zero requested this cycle
module reg_cell
    import register_bank_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int LANE     = 8,
    parameter int SATURATE = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 we,
    input  logic [2:0]                           funsel,
    input  logic [idx_w(nlane(WIDTH, LANE))-1:0] lanesel,
    input  logic [WIDTH-1:0]                     load,
    input  logic [LANE-1:0]                      lane_data,
    output logic [WIDTH-1:0]                     q,
    output logic                                 bnd
);

    localparam int NLANE = nlane(WIDTH, LANE);
    localparam int LSW   = idx_w(NLANE);

    logic             at_max;
    logic             at_min;
    logic [WIDTH-1:0] d;

    assign at_max = &q;
    assign at_min = (q == '0);
    assign bnd    = ((funsel == FS_INC) && at_max) || ((funsel == FS_DEC) && at_min);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        d = q;
        case (funsel)
            FS_CLR:  d = '0;
            FS_LOAD: d = load;
            FS_DEC:  d = (SATURATE != 0 && at_min) ? q : q - WIDTH'(1);
            FS_INC:  d = (SATURATE != 0 && at_max) ? q : q + WIDTH'(1);
            FS_LANE: begin
                // An index with no matching lane leaves d unchanged.
                for (int l = 0; l < NLANE; l++) begin
                    if (lanesel == LSW'(l)) begin
                        d[l*LANE +: LANE] = lane_data;
                    end
                end
            end
            default: d = q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    // NOTE: the bank is a handful of flops, not a RAM, so each register is
    // reset; a real memory array would be left unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_bank.sv
// register_bank
//   NREG general-purpose registers sharing one function select. Selected
//   registers apply the same operation at each edge; two combinational read
//   ports and a registered wrap/clamp status flag.
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   enable     global write enable
//   regsel     mask of registers affected this cycle
//   funsel     operation code (see register_bank_pkg)
//   lanesel    lane index for lane loads
//   load       full-width load data
//   lane_data  lane load data
//   osel_a/b   read-port register indices (out of range reads 0)
//   out_a/b    read-port data
//   ovf        last edge's inc/dec hit the boundary in a selected register
module register_bank
    import register_bank_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int NREG     = 4,
    parameter int LANE     = 8,
    parameter int SATURATE = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic [NREG-1:0]                      regsel,
    input  logic [2:0]                           funsel,
    input  logic [idx_w(nlane(WIDTH, LANE))-1:0] lanesel,
    input  logic [WIDTH-1:0]                     load,
    input  logic [LANE-1:0]                      lane_data,
    input  logic [idx_w(NREG)-1:0]               osel_a,
    input  logic [idx_w(NREG)-1:0]               osel_b,
    output logic [WIDTH-1:0]                     out_a,
    output logic [WIDTH-1:0]                     out_b,
    output logic                                 ovf
);

    localparam int OSW = idx_w(NREG);

    logic [WIDTH-1:0] regs [NREG];
    logic [NREG-1:0]  bnd;

    for (genvar i = 0; i < NREG; i++) begin : g_cell
        reg_cell #(
            .WIDTH    (WIDTH),
            .LANE     (LANE),
            .SATURATE (SATURATE)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .we        (enable & regsel[i]),
            .funsel    (funsel),
            .lanesel   (lanesel),
            .load      (load),
            .lane_data (lane_data),
            .q         (regs[i]),
            .bnd       (bnd[i])
        );
    end

    // bnd is only non-zero for inc/dec, so masking it with the selection
    // covers the hold codes and the empty mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= enable & |(regsel & bnd);
        end
    end

    always_comb begin
        out_a = '0;
        out_b = '0;
        for (int i = 0; i < NREG; i++) begin
            if (osel_a == OSW'(i)) out_a = regs[i];
            if (osel_b == OSW'(i)) out_b = regs[i];
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: a wrap-mode and a saturate-mode
// instance share every input, so each step checks both behaviours.
module tb_register_bank;
    import register_bank_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  regsel;
    logic [2:0]  funsel;
    logic [0:0]  lanesel;
    logic [15:0] load;
    logic [7:0]  lane_data;
    logic [1:0]  osel_a;
    logic [1:0]  osel_b;
    logic [15:0] out_a_w, out_b_w, out_a_s, out_b_s;
    logic        ovf_w, ovf_s;

    int total  = 0;
    int passed = 0;

    always #10 clk = ~clk;

    register_bank #(.WIDTH(16), .NREG(4), .LANE(8), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .enable(enable), .regsel(regsel), .funsel(funsel),
        .lanesel(lanesel), .load(load), .lane_data(lane_data),
        .osel_a(osel_a), .osel_b(osel_b), .out_a(out_a_w), .out_b(out_b_w), .ovf(ovf_w)
    );

    register_bank #(.WIDTH(16), .NREG(4), .LANE(8), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .enable(enable), .regsel(regsel), .funsel(funsel),
        .lanesel(lanesel), .load(load), .lane_data(lane_data),
        .osel_a(osel_a), .osel_b(osel_b), .out_a(out_a_s), .out_b(out_b_s), .ovf(ovf_s)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock edge; returns 1 time unit after it, away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read register idx on port A of both instances.
    task automatic rd(input string tag, input int idx, input logic [15:0] ew, input logic [15:0] es);
        osel_a = 2'(idx);
        #1;
        check({tag, "_w"}, out_a_w, ew);
        check({tag, "_s"}, out_a_s, es);
    endtask

    task automatic chk_ovf(input string tag, input logic ew, input logic es);
        check({tag, "_ovf_w"}, {15'd0, ovf_w}, {15'd0, ew});
        check({tag, "_ovf_s"}, {15'd0, ovf_s}, {15'd0, es});
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; regsel = 4'b1111; funsel = FS_LOAD;
        lanesel = 1'b0; load = 16'hFFFF; lane_data = 8'h00; osel_a = 2'd0; osel_b = 2'd0;

        // Reset beats a coincident load.
        step();
        rst = 1'b0; enable = 1'b0;
        rd("rst_r0", 0, 16'h0000, 16'h0000);
        rd("rst_r1", 1, 16'h0000, 16'h0000);
        rd("rst_r2", 2, 16'h0000, 16'h0000);
        rd("rst_r3", 3, 16'h0000, 16'h0000);
        chk_ovf("rst", 1'b0, 1'b0);

        // Multi-register load, dual read.
        enable = 1'b1; regsel = 4'b0101; funsel = FS_LOAD; load = 16'h1234;
        step();
        enable = 1'b0;
        osel_a = 2'd0; osel_b = 2'd2;
        #1;
        check("mload_a", out_a_w, 16'h1234);
        check("mload_b", out_b_w, 16'h1234);
        osel_a = 2'd1; osel_b = 2'd3;
        #1;
        check("mload_r1", out_a_w, 16'h0000);
        check("mload_r3", out_b_s, 16'h0000);

        // Lane loads into R1.
        enable = 1'b1; regsel = 4'b0010; funsel = FS_LANE; lanesel = 1'b1; lane_data = 8'hAB;
        step();
        rd("lane_hi", 1, 16'hAB00, 16'hAB00);
        lanesel = 1'b0; lane_data = 8'hCD;
        step();
        rd("lane_lo", 1, 16'hABCD, 16'hABCD);
        rd("lane_r2", 2, 16'h1234, 16'h1234);

        // Wrap vs clamp at all-ones.
        regsel = 4'b0001; funsel = FS_LOAD; load = 16'hFFFF;
        step();
        funsel = FS_INC;
        step();
        rd("inc_max", 0, 16'h0000, 16'hFFFF);
        chk_ovf("inc_max", 1'b1, 1'b1);
        funsel = 3'b101;
        step();
        rd("hold", 0, 16'h0000, 16'hFFFF);
        chk_ovf("hold", 1'b0, 1'b0);
        funsel = FS_DEC;
        step();
        rd("dec_w0", 0, 16'hFFFF, 16'hFFFE);
        chk_ovf("dec_w0", 1'b1, 1'b0);

        // Clamp at zero.
        funsel = FS_LOAD; load = 16'h0000;
        step();
        chk_ovf("load0", 1'b0, 1'b0);
        funsel = FS_DEC;
        step();
        rd("dec0_a", 0, 16'hFFFF, 16'h0000);
        chk_ovf("dec0_a", 1'b1, 1'b1);
        step();
        rd("dec0_b", 0, 16'hFFFE, 16'h0000);
        chk_ovf("dec0_b", 1'b0, 1'b1);
        funsel = FS_INC;
        step();
        rd("inc1", 0, 16'hFFFF, 16'h0001);
        chk_ovf("inc1", 1'b0, 1'b0);

        // Clear, then a two-register dec where only R0 is at the boundary.
        funsel = FS_CLR;
        step();
        rd("clr", 0, 16'h0000, 16'h0000);
        regsel = 4'b0101; funsel = FS_DEC;
        step();
        rd("mdec_r0", 0, 16'hFFFF, 16'h0000);
        rd("mdec_r2", 2, 16'h1233, 16'h1233);
        chk_ovf("mdec", 1'b1, 1'b1);

        // Empty mask is a no-op with ovf cleared.
        regsel = 4'b0000; funsel = FS_DEC;
        step();
        rd("empty_r2", 2, 16'h1233, 16'h1233);
        chk_ovf("empty", 1'b0, 1'b0);

        // Global enable low: nothing changes, no ovf even at a boundary.
        enable = 1'b0; regsel = 4'b1111; funsel = FS_INC;
        step();
        rd("gate_inc_r0", 0, 16'hFFFF, 16'h0000);
        chk_ovf("gate_inc", 1'b0, 1'b0);
        funsel = FS_CLR;
        step();
        rd("gate_clr_r1", 1, 16'hABCD, 16'hABCD);
        rd("gate_clr_r2", 2, 16'h1233, 16'h1233);

        // Set ovf, then reset with a coincident inc.
        enable = 1'b1; regsel = 4'b0001; funsel = FS_INC;
        step();
        chk_ovf("pre_rst", 1'b1, 1'b0);
        rst = 1'b1; regsel = 4'b1111; funsel = FS_INC;
        step();
        rst = 1'b0; enable = 1'b0;
        rd("rst2_r0", 0, 16'h0000, 16'h0000);
        rd("rst2_r1", 1, 16'h0000, 16'h0000);
        rd("rst2_r2", 2, 16'h0000, 16'h0000);
        rd("rst2_r3", 3, 16'h0000, 16'h0000);
        chk_ovf("rst2", 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Parametrised bank of NREG general-purpose registers, each WIDTH bits, sharing one function-select bus.
- Generalises the single clear/load/dec/inc register and the byte-lane-loaded instruction register.
- Adds per-register write mask, lane-granular loads, optional saturating arithmetic, two read ports and a wrap/saturate status flag.
- Sits between the data bus and the ALU operand muxes.

Parameters:
- WIDTH, 16, register width in bits; must be a multiple of LANE.
- NREG, 4, number of registers; minimum 2.
- LANE, 8, lane width for partial loads; NLANE = WIDTH/LANE.
- SATURATE, 0, 0 = inc/dec wrap modulo 2^WIDTH; 1 = inc/dec clamp at all-ones/zero.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  global write enable; 0 means no register changes.
- regsel  in  NREG  one-hot-or-multi mask of registers affected this cycle.
- funsel  in  3  operation code (see Behaviour).
- lanesel  in  max(1,clog2(NLANE))  lane index for lane load.
- load  in  WIDTH  full-width load data.
- lane_data  in  LANE  lane load data.
- osel_a  in  max(1,clog2(NREG))  read-port A register index.
- osel_b  in  max(1,clog2(NREG))  read-port B register index.
- out_a  out  WIDTH  contents of register osel_a.
- out_b  out  WIDTH  contents of register osel_b.
- ovf  out  1  registered status: an inc/dec in the previous cycle wrapped or hit a clamp.

Behaviour:
- Reset: rst=1 at a clk edge sets all registers to 0 and ovf to 0. It overrides enable and funsel. The next cycle's out_a/out_b read 0.
- Update rule: a register i changes only when enable=1, regsel[i]=1 and rst=0. All selected registers apply the same funsel in the same edge.
- funsel codes:
  - 000 clear: reg <= 0.
  - 001 load: reg <= load.
  - 010 dec: reg <= reg - 1.
  - 011 inc: reg <= reg + 1.
  - 100 lane load: reg[lanesel*LANE +: LANE] <= lane_data; other lanes hold.
  - 101/110/111: hold (no change, ovf <= 0).
- Lane range: lanesel >= NLANE makes the lane load a no-op.
- Wrap mode (SATURATE=0): inc of all-ones gives 0; dec of 0 gives all-ones.
- Saturate mode (SATURATE=1): inc of all-ones holds all-ones; dec of 0 holds 0.
- ovf: updated every edge. It is 1 if enable=1 and funsel is inc/dec and at least one selected register was at the boundary (all-ones for inc, 0 for dec). Otherwise 0. It is set in both modes.
- Empty mask: regsel=0 with enable=1 is a no-op, and ovf <= 0.
- Read ports: out_a/out_b are combinational muxes of current register state, 0-cycle read latency. An index >= NREG reads 0. A write becomes visible on the outputs the cycle after the edge (no write-through).
- Latency: all writes take effect at the single clk edge, and there is no multi-cycle state. Both read ports may select the same register.

Decomposition:
- Package register_bank_pkg holds the funsel localparams FS_CLR, FS_LOAD, FS_DEC, FS_INC, FS_LANE and the NLANE/index-width helper functions.
- Sub-module reg_cell (WIDTH, LANE, SATURATE) implements one register with its own boundary-detect output. It is instantiated NREG times via generate.
- The top-level ORs the gated boundary signals into the ovf flop and builds the read muxes.

Test Plan:
- Reset then read: rst=1 for 1 cycle with enable=1, funsel=001, load=16'hFFFF → all registers 0, out_a=out_b=16'h0000, ovf=0.
- Multi-register load and dual read: regsel=4'b0101, funsel=001, load=16'h1234, then osel_a=0, osel_b=2 → out_a=out_b=16'h1234; registers 1 and 3 stay 0.
- Lane load: R1=16'h0000; funsel=100, lanesel=1, lane_data=8'hAB → R1=16'hAB00. Then lanesel=0, lane_data=8'hCD → R1=16'hABCD.
- Wrap (SATURATE=0): R0=16'hFFFF, funsel=011 → R0=16'h0000 and ovf=1 for exactly one cycle. Then funsel=010 → R0=16'hFFFF, ovf=1.
- Saturate (SATURATE=1): R0=16'h0000, funsel=010 twice → R0 stays 16'h0000 with ovf=1 each cycle. Then inc → R0=16'h0001, ovf=0.
- Gating and reset priority: enable=0 with funsel=000 → no change. Next, rst=1 coincident with enable=1, funsel=011 → all registers 0, ovf=0.
